// File: rtl/cmp_pkg.sv
// Shared types for the serial magnitude comparator: FSM state encoding and
// the slice-count helper.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int unsigned cmp_steps(input int unsigned width,
                                            input int unsigned digit);
    return width / digit;
  endfunction

endpackage

// File: rtl/cmp_digit_cell.sv
// One DIGIT-wide stage of the greater/equal propagate cascade. Combinational.
module cmp_digit_cell #(
  parameter int unsigned DIGIT = 1
) (
  input  logic [DIGIT-1:0] sliceA,
  input  logic [DIGIT-1:0] sliceB,
  input  logic             is_signed_msb,
  input  logic             g_in,
  input  logic             e_in,
  input  logic             l_in,
  output logic             g_out,
  output logic             e_out,
  output logic             l_out
);

  localparam logic [DIGIT-1:0] MSB_MASK = DIGIT'(1) << (DIGIT - 1);

  logic [DIGIT-1:0] w_a;
  logic [DIGIT-1:0] w_b;

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  assign w_a = sliceA ^ (is_signed_msb ? MSB_MASK : '0);
  assign w_b = sliceB ^ (is_signed_msb ? MSB_MASK : '0);

  assign g_out = g_in | (e_in & (w_a > w_b));
  assign l_out = l_in | (e_in & (w_a < w_b));
  assign e_out = e_in & (w_a == w_b);

endmodule

// File: rtl/serial_mag_comparator.sv
// Multi-cycle MSB-first magnitude comparator: resolves DIGIT bits per clock,
// unsigned or two's-complement, with optional early termination.
module serial_mag_comparator #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DIGIT      = 1,
  parameter bit          EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  import cmp_pkg::*;

  localparam int unsigned STEPS = cmp_steps(WIDTH, DIGIT);
  localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int unsigned IDX_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_signed;
  logic [CNT_W-1:0] r_cnt;
  logic             r_g_acc;
  logic             r_e_acc;
  logic             r_l_acc;
  logic             r_done;
  logic             r_gt;
  logic             r_eq;
  logic             r_lt;

  logic [IDX_W-1:0] w_base;
  logic [DIGIT-1:0] w_slice_a;
  logic [DIGIT-1:0] w_slice_b;
  logic             w_g;
  logic             w_e;
  logic             w_l;
  logic             w_exit;

  assign w_base    = IDX_W'(WIDTH - 1) - IDX_W'(32'(r_cnt) * DIGIT);
  assign w_slice_a = r_a[w_base -: DIGIT];
  assign w_slice_b = r_b[w_base -: DIGIT];

  cmp_digit_cell #(
    .DIGIT(DIGIT)
  ) u_cell (
    .sliceA       (w_slice_a),
    .sliceB       (w_slice_b),
    .is_signed_msb(r_signed && (r_cnt == '0)),
    .g_in         (r_g_acc),
    .e_in         (r_e_acc),
    .l_in         (r_l_acc),
    .g_out        (w_g),
    .e_out        (w_e),
    .l_out        (w_l)
  );

  assign w_exit = (r_cnt == LAST) || (EARLY_EXIT && !w_e);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_signed <= 1'b0;
      r_cnt    <= '0;
      r_g_acc  <= 1'b0;
      r_e_acc  <= 1'b0;
      r_l_acc  <= 1'b0;
      r_done   <= 1'b0;
      r_gt     <= 1'b0;
      r_eq     <= 1'b0;
      r_lt     <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          r_g_acc <= w_g;
          r_e_acc <= w_e;
          r_l_acc <= w_l;
          r_cnt   <= r_cnt + 1'b1;
          if (w_exit) begin
            r_gt    <= w_g;
            r_eq    <= w_e;
            r_lt    <= w_l;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        default: begin
          // IDLE and DONE both accept a new request; done lasts one cycle.
          r_done <= 1'b0;
          if (start) begin
            r_a      <= a;
            r_b      <= b;
            r_signed <= signed_mode;
            r_cnt    <= '0;
            r_g_acc  <= 1'b0;
            r_e_acc  <= 1'b1;
            r_l_acc  <= 1'b0;
            r_gt     <= 1'b0;
            r_eq     <= 1'b0;
            r_lt     <= 1'b0;
            r_state  <= RUN;
          end
        end
      endcase
    end
  end

  assign busy = (r_state == RUN);
  assign done = r_done;
  assign gt   = r_gt;
  assign eq   = r_eq;
  assign lt   = r_lt;

endmodule
